// File: rtl/ysyx_24070016_pkg.sv
// Shared encodings for the ysyx_24070016 write-back path:
// result-source select, load funct3 codes, response codes and WBU states.
package ysyx_24070016_pkg;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_ALT  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] RESP_OK = 2'b00;

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_WAIT_MEM = 2'b01,
      S_WRITE    = 2'b10
   } wbu_state_e;

endpackage

// File: rtl/ysyx_24070016_load_align.sv
// Combinational load extractor: picks the byte/halfword addressed inside an
// aligned 32-bit word and sign- or zero-extends it according to funct3.
module ysyx_24070016_load_align
   import ysyx_24070016_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] word,
   input  logic [1:0]            addr,
   input  logic [2:0]            funct3,
   output logic [DATA_WIDTH-1:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (addr)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      // Halfword loads ignore addr[0]; misaligned halves read the enclosing pair.
      half_v = addr[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_LB:   data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
         F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
         F3_LH:   data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
         F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, half_v};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/ysyx_24070016_wbu.sv
// Write-back unit: holds one retired instruction, waits for load data when
// needed, then drives a single register-file write and a commit pulse.
module ysyx_24070016_wbu
   import ysyx_24070016_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_wb_en,
   input  logic [1:0]            in_wb_sel,
   input  logic [DATA_WIDTH-1:0] in_result,
   input  logic [DATA_WIDTH-1:0] in_pc,
   input  logic [2:0]            in_ld_funct3,

   input  logic                  mem_rvalid,
   output logic                  mem_rready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic [1:0]            mem_rresp,

   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,

   output logic                  commit_valid,
   output logic [DATA_WIDTH-1:0] commit_pc,
   output logic                  commit_err,

   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] busy_rd
);

   wbu_state_e            state_p1;
   logic [ADDR_WIDTH-1:0] rd_p1;
   logic                  wb_en_p1;
   logic [1:0]            wb_sel_p1;
   logic [DATA_WIDTH-1:0] result_p1;
   logic [DATA_WIDTH-1:0] pc_p1;
   logic [2:0]            funct3_p1;
   logic [DATA_WIDTH-1:0] rdata_p1;
   logic                  fault_p1;

   logic                  fire;
   logic                  in_write;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] ld_data;
   logic [DATA_WIDTH-1:0] wb_value;

   function automatic logic [DATA_WIDTH-1:0] next_pc(input logic [DATA_WIDTH-1:0] pc);
      return pc + DATA_WIDTH'(4);
   endfunction

   assign in_ready   = (state_p1 != S_WAIT_MEM);
   assign fire       = in_valid && in_ready;
   assign mem_rready = (state_p1 == S_WAIT_MEM);
   assign in_write   = (state_p1 == S_WRITE);
   assign busy       = (state_p1 != S_IDLE);

   // ---- capture stage: accept an instruction or a load response ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1 <= S_IDLE;
      end else begin
         case (state_p1)
            S_WAIT_MEM: begin
               if (mem_rvalid) state_p1 <= S_WRITE;
            end
            default: begin
               if (fire) state_p1 <= (in_wb_sel == WB_LOAD) ? S_WAIT_MEM : S_WRITE;
               else      state_p1 <= S_IDLE;
            end
         endcase
      end
   end

   // Payload registers carry no reset; every output they feed is gated by state.
   always_ff @(posedge clk) begin
      if (fire) begin
         rd_p1     <= in_rd;
         wb_en_p1  <= in_wb_en;
         wb_sel_p1 <= in_wb_sel;
         result_p1 <= in_result;
         pc_p1     <= in_pc;
         funct3_p1 <= in_ld_funct3;
         fault_p1  <= 1'b0;
      end else if (mem_rready && mem_rvalid) begin
         rdata_p1  <= mem_rdata;
         fault_p1  <= (mem_rresp != RESP_OK);
      end
   end

   ysyx_24070016_load_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_align (
      .word   (rdata_p1),
      .addr   (result_p1[1:0]),
      .funct3 (funct3_p1),
      .data   (ld_data)
   );

   // ---- write stage: outputs derive only from captured registers ----
   always_comb begin
      case (wb_sel_p1)
         WB_LOAD: wb_value = ld_data;
         WB_PC4:  wb_value = next_pc(pc_p1);
         default: wb_value = result_p1;
      endcase
   end

   // RV32E has only x0..x15; x0 and faulted loads never write.
   assign rd_valid     = (rd_p1 != '0) && (rd_p1 < ADDR_WIDTH'(16));

   assign rf_wen       = in_write && wb_en_p1 && rd_valid && !fault_p1;
   assign rf_waddr     = in_write ? rd_p1    : '0;
   assign rf_wdata     = in_write ? wb_value : '0;
   assign commit_valid = in_write;
   assign commit_pc    = in_write ? pc_p1    : '0;
   assign commit_err   = in_write && fault_p1;
   assign busy_rd      = (busy && wb_en_p1 && (rd_p1 != '0)) ? rd_p1 : '0;

endmodule

// File: tb/tb_ysyx_24070016_wbu.sv
// Directed bench for the write-back unit with hand-computed expectations.
module tb_ysyx_24070016_wbu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_wb_en;
   logic [1:0]  in_wb_sel;
   logic [31:0] in_result;
   logic [31:0] in_pc;
   logic [2:0]  in_ld_funct3;
   logic        mem_rvalid;
   logic        mem_rready;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_rresp;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        commit_err;
   logic        busy;
   logic [4:0]  busy_rd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_24070016_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rd        (in_rd),
      .in_wb_en     (in_wb_en),
      .in_wb_sel    (in_wb_sel),
      .in_result    (in_result),
      .in_pc        (in_pc),
      .in_ld_funct3 (in_ld_funct3),
      .mem_rvalid   (mem_rvalid),
      .mem_rready   (mem_rready),
      .mem_rdata    (mem_rdata),
      .mem_rresp    (mem_rresp),
      .rf_wen       (rf_wen),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .commit_err   (commit_err),
      .busy         (busy),
      .busy_rd      (busy_rd)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic en,
                        input logic [1:0] sel, input logic [31:0] res,
                        input logic [31:0] pc, input logic [2:0] f3);
      in_valid     = v;
      in_rd        = rd;
      in_wb_en     = en;
      in_wb_sel    = sel;
      in_result    = res;
      in_pc        = pc;
      in_ld_funct3 = f3;
   endtask

   task automatic idle_in();
      drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 3'b000);
   endtask

   initial begin
      rst_n      = 1'b0;
      idle_in();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      mem_rresp  = 2'b00;

      // Reset values
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_commit", 32'(commit_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_rf_wen", 32'(rf_wen), 32'd0);
      check("rst_mem_rready", 32'(mem_rready), 32'd0);
      check("rst_busy_rd", 32'(busy_rd), 32'd0);

      // ALU op rd=5
      drive(1'b1, 5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'h0000_0100, 3'b000);
      check("alu_in_ready", 32'(in_ready), 32'd1);
      tick();
      idle_in();
      check("alu_wen", 32'(rf_wen), 32'd1);
      check("alu_waddr", 32'(rf_waddr), 32'd5);
      check("alu_wdata", rf_wdata, 32'h0000_1234);
      check("alu_commit", 32'(commit_valid), 32'd1);
      check("alu_cpc", commit_pc, 32'h0000_0100);
      check("alu_busy_rd", 32'(busy_rd), 32'd5);
      tick();
      check("alu_commit_once", 32'(commit_valid), 32'd0);
      check("alu_idle_busy", 32'(busy), 32'd0);

      // Stray response in IDLE is ignored
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      check("idle_rready", 32'(mem_rready), 32'd0);
      tick();
      mem_rvalid = 1'b0;
      check("idle_no_commit", 32'(commit_valid), 32'd0);

      // LB at addr ...3, response three cycles after acceptance
      drive(1'b1, 5'd7, 1'b1, 2'b01, 32'h0000_1003, 32'h0000_0200, 3'b000);
      tick();
      idle_in();
      check("lb_in_ready_w1", 32'(in_ready), 32'd0);
      check("lb_rready", 32'(mem_rready), 32'd1);
      check("lb_busy_rd", 32'(busy_rd), 32'd7);
      check("lb_no_wen_w1", 32'(rf_wen), 32'd0);
      tick();
      check("lb_in_ready_w2", 32'(in_ready), 32'd0);
      tick();
      check("lb_in_ready_w3", 32'(in_ready), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h80FF_FF7F;
      mem_rresp  = 2'b00;
      tick();
      mem_rvalid = 1'b0;
      check("lb_wen", 32'(rf_wen), 32'd1);
      check("lb_waddr", 32'(rf_waddr), 32'd7);
      check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
      check("lb_err", 32'(commit_err), 32'd0);
      check("lb_cpc", commit_pc, 32'h0000_0200);
      check("lb_in_ready_wr", 32'(in_ready), 32'd1);
      tick();
      check("lb_commit_once", 32'(commit_valid), 32'd0);

      // LHU at addr[1]=1
      drive(1'b1, 5'd9, 1'b1, 2'b01, 32'h0000_2002, 32'h0000_0300, 3'b101);
      tick();
      idle_in();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBEEF_0000;
      tick();
      mem_rvalid = 1'b0;
      check("lhu_wen", 32'(rf_wen), 32'd1);
      check("lhu_wdata", rf_wdata, 32'h0000_BEEF);

      // LH at addr 0 sign-extends; LBU at addr 1 zero-extends; LW raw
      drive(1'b1, 5'd10, 1'b1, 2'b01, 32'h0000_2000, 32'h0000_0304, 3'b001);
      tick();
      idle_in();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_8001;
      tick();
      mem_rvalid = 1'b0;
      check("lh_wdata", rf_wdata, 32'hFFFF_8001);
      drive(1'b1, 5'd11, 1'b1, 2'b01, 32'h0000_2001, 32'h0000_0308, 3'b100);
      tick();
      idle_in();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_9A00;
      tick();
      mem_rvalid = 1'b0;
      check("lbu_wdata", rf_wdata, 32'h0000_009A);
      drive(1'b1, 5'd12, 1'b1, 2'b01, 32'h0000_2003, 32'h0000_030C, 3'b010);
      tick();
      idle_in();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      tick();
      mem_rvalid = 1'b0;
      check("lw_wdata", rf_wdata, 32'hCAFE_F00D);

      // Faulting load
      drive(1'b1, 5'd4, 1'b1, 2'b01, 32'h0000_3000, 32'h0000_0400, 3'b010);
      tick();
      idle_in();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111_1111;
      mem_rresp  = 2'b10;
      tick();
      mem_rvalid = 1'b0;
      mem_rresp  = 2'b00;
      check("fault_wen", 32'(rf_wen), 32'd0);
      check("fault_commit", 32'(commit_valid), 32'd1);
      check("fault_err", 32'(commit_err), 32'd1);
      tick();

      // wb_sel=11 behaves as ALU
      drive(1'b1, 5'd2, 1'b1, 2'b11, 32'h0000_A5A5, 32'h0000_0500, 3'b000);
      tick();
      idle_in();
      check("sel11_wdata", rf_wdata, 32'h0000_A5A5);
      check("sel11_wen", 32'(rf_wen), 32'd1);
      tick();

      // Back-to-back: rd=0, rd=20, rd=3 with pc+4 wrapping
      drive(1'b1, 5'd0, 1'b1, 2'b00, 32'h0000_0055, 32'h0000_0010, 3'b000);
      tick();
      check("b2b0_commit", 32'(commit_valid), 32'd1);
      check("b2b0_wen", 32'(rf_wen), 32'd0);
      check("b2b0_in_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 5'd20, 1'b1, 2'b00, 32'h0000_0066, 32'h0000_0014, 3'b000);
      tick();
      check("b2b1_commit", 32'(commit_valid), 32'd1);
      check("b2b1_wen", 32'(rf_wen), 32'd0);
      check("b2b1_cpc", commit_pc, 32'h0000_0014);
      drive(1'b1, 5'd3, 1'b1, 2'b10, 32'h0000_0077, 32'hFFFF_FFFC, 3'b000);
      tick();
      idle_in();
      check("b2b2_commit", 32'(commit_valid), 32'd1);
      check("b2b2_wen", 32'(rf_wen), 32'd1);
      check("b2b2_waddr", 32'(rf_waddr), 32'd3);
      check("b2b2_wdata", rf_wdata, 32'h0000_0000);
      check("b2b2_cpc", commit_pc, 32'hFFFF_FFFC);
      tick();
      check("b2b_end", 32'(commit_valid), 32'd0);

      // Reset during WAIT_MEM drops the load
      drive(1'b1, 5'd6, 1'b1, 2'b01, 32'h0000_4000, 32'h0000_0600, 3'b010);
      tick();
      idle_in();
      check("mid_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      rst_n      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_5555;
      tick();
      mem_rvalid = 1'b0;
      check("mid_no_commit", 32'(commit_valid), 32'd0);
      check("mid_no_wen", 32'(rf_wen), 32'd0);
      check("mid_busy_after", 32'(busy), 32'd0);
      tick();
      check("mid_no_commit2", 32'(commit_valid), 32'd0);
      check("mid_busy_rd", 32'(busy_rd), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
